// File: rtl/lui_unit_pkg.sv
//------------------------------------------------------------------------------
// Module   : lui_unit_pkg
// Brief    : Shared MIPS immediate-extension mode encodings.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package lui_unit_pkg;

    localparam int c_IMM_W = 16;
    localparam int c_OUT_W = 32;

    typedef enum logic [1:0] {
        MODE_LUI    = 2'b00,
        MODE_SEXT   = 2'b01,
        MODE_ZEXT   = 2'b10,
        MODE_BRANCH = 2'b11
    } imm_mode_e;

endpackage

`default_nettype wire

// File: rtl/lui_unit_imm_ext.sv
//------------------------------------------------------------------------------
// Module   : imm_ext
// Brief    : Combinational 16-to-32-bit immediate extender (LUI/SEXT/ZEXT/BRANCH).
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module imm_ext
    import lui_unit_pkg::*;
(
    input  logic [c_IMM_W-1:0] immed,
    input  logic [1:0]         mode,
    output logic [c_OUT_W-1:0] ext_o
);

    always_comb begin
        ext_o = '0;
        case (imm_mode_e'(mode))
            MODE_LUI:    ext_o = {immed, 16'h0000};
            MODE_SEXT:   ext_o = {{16{immed[15]}}, immed};
            MODE_ZEXT:   ext_o = {16'h0000, immed};
            // Word offset: top two sign copies fall off bit 31.
            MODE_BRANCH: ext_o = {{14{immed[15]}}, immed, 2'b00};
            default:     ext_o = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/lui_unit.sv
//------------------------------------------------------------------------------
// Module   : lui_unit
// Brief    : Immediate generator wrapping imm_ext with optional output register.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module lui_unit
    import lui_unit_pkg::*;
#(
    parameter int OUT_REG = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [c_IMM_W-1:0] immed,
    input  logic [1:0]         mode,
    output logic [c_OUT_W-1:0] lui_out,
    output logic               out_valid
);

    logic [c_OUT_W-1:0] w_ext;

    imm_ext u_imm_ext (
        .immed (immed),
        .mode  (mode),
        .ext_o (w_ext)
    );

    generate
        if (OUT_REG != 0) begin : g_reg
            logic [c_OUT_W-1:0] lui_out_q;
            logic [c_OUT_W-1:0] lui_out_d;
            logic               out_valid_q;

            // Result holds when idle; only the valid flag drops.
            assign lui_out_d = in_valid ? w_ext : lui_out_q;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    lui_out_q   <= '0;
                    out_valid_q <= 1'b0;
                end else begin
                    lui_out_q   <= lui_out_d;
                    out_valid_q <= in_valid;
                end
            end

            assign lui_out   = lui_out_q;
            assign out_valid = out_valid_q;
        end else begin : g_comb
            logic w_unused;
            assign w_unused  = clk ^ reset;
            assign lui_out   = w_ext;
            assign out_valid = in_valid;
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_lui_unit.sv
//------------------------------------------------------------------------------
// Module   : tb_lui_unit
// Brief    : Directed self-checking bench for registered and combinational lui_unit.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_lui_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [15:0] immed;
    logic [1:0]  mode;
    logic [31:0] r_out;
    logic        r_vld;
    logic [31:0] c_out;
    logic        c_vld;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    lui_unit #(.OUT_REG(1)) u_dut_reg (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .immed     (immed),
        .mode      (mode),
        .lui_out   (r_out),
        .out_valid (r_vld)
    );

    lui_unit #(.OUT_REG(0)) u_dut_comb (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .immed     (immed),
        .mode      (mode),
        .lui_out   (c_out),
        .out_valid (c_vld)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic [15:0] i, input logic [1:0] m);
        in_valid = 1'b1;
        immed    = i;
        mode     = m;
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b1;
        immed    = 16'hFFFF;
        mode     = 2'b00;

        // Reset state, and valid input ignored while reset is high
        #2;
        check("rst_out", r_out, 32'h0);
        check("rst_vld", {31'b0, r_vld}, 32'h0);
        @(posedge clk); #1;
        check("rst_hold_out", r_out, 32'h0);
        check("rst_hold_vld", {31'b0, r_vld}, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Back-to-back LUI requests
        req(16'h0AB5, 2'b00);
        @(posedge clk); #1;
        check("lui_0ab5", r_out, 32'h0AB5_0000);
        check("lui_0ab5_vld", {31'b0, r_vld}, 32'h1);
        req(16'h0000, 2'b00);
        @(posedge clk); #1;
        check("lui_0000", r_out, 32'h0000_0000);
        check("lui_0000_vld", {31'b0, r_vld}, 32'h1);
        req(16'h43E2, 2'b00);
        @(posedge clk); #1;
        check("lui_43e2", r_out, 32'h43E2_0000);
        req(16'h6402, 2'b00);
        @(posedge clk); #1;
        check("lui_6402", r_out, 32'h6402_0000);
        check("lui_6402_vld", {31'b0, r_vld}, 32'h1);

        // Extension modes on a negative immediate
        req(16'h8000, 2'b01);
        @(posedge clk); #1;
        check("sext_8000", r_out, 32'hFFFF_8000);
        req(16'h8000, 2'b10);
        @(posedge clk); #1;
        check("zext_8000", r_out, 32'h0000_8000);
        req(16'h8000, 2'b11);
        @(posedge clk); #1;
        check("br_8000", r_out, 32'hFFFE_0000);
        req(16'h1234, 2'b11);
        @(posedge clk); #1;
        check("br_1234", r_out, 32'h0000_48D0);

        // Hold while idle, input changes ignored
        req(16'hFFFF, 2'b00);
        @(posedge clk); #1;
        check("lui_ffff", r_out, 32'hFFFF_0000);
        in_valid = 1'b0;
        immed    = 16'h1234;
        @(posedge clk); #1;
        check("idle_hold", r_out, 32'hFFFF_0000);
        check("idle_vld", {31'b0, r_vld}, 32'h0);
        immed = 16'h5A5A;
        mode  = 2'b10;
        @(posedge clk); #1;
        check("idle_hold2", r_out, 32'hFFFF_0000);

        // Asynchronous reset mid-stream discards the pending request
        req(16'h43E2, 2'b00);
        @(posedge clk); #1;
        check("pre_rst", r_out, 32'h43E2_0000);
        req(16'h5555, 2'b00);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_out", r_out, 32'h0);
        check("async_rst_vld", {31'b0, r_vld}, 32'h0);
        @(posedge clk); #1;
        check("rst_no_pending", r_out, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        req(16'h0001, 2'b00);
        @(posedge clk); #1;
        check("post_rst", r_out, 32'h0001_0000);
        check("post_rst_vld", {31'b0, r_vld}, 32'h1);

        // Combinational variant: same-cycle result, valid passthrough
        @(negedge clk);
        req(16'h7FFF, 2'b11);
        #1;
        check("comb_br_7fff", c_out, 32'h0001_FFFC);
        check("comb_vld1", {31'b0, c_vld}, 32'h1);
        in_valid = 1'b0;
        #1;
        check("comb_vld0", {31'b0, c_vld}, 32'h0);
        immed = 16'h8000;
        mode  = 2'b01;
        #1;
        check("comb_sext_8000", c_out, 32'hFFFF_8000);
        mode = 2'b00;
        immed = 16'hABCD;
        #1;
        check("comb_lui_abcd", c_out, 32'hABCD_0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/lui_unit.md
LUI_UNIT -- requirements
Module: lui_unit

Interface
REQ-001 Parameter OUT_REG, default 1; 1 = registered outputs (1-cycle latency), 0 = combinational outputs (0-cycle latency, clock/reset unused).
REQ-002 clk  input  1  single system clock, rising-edge active.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  qualifies immed/mode for this cycle.
REQ-005 immed  input  16  instruction immediate field, bits [15:0].
REQ-006 mode  input  2  extension select: 00 LUI, 01 sign-extend, 10 zero-extend, 11 sign-extend shifted left 2 (branch offset).
REQ-007 lui_out  output  32  generated 32-bit immediate.
REQ-008 out_valid  output  1  lui_out holds a result for a valid request.

Function
REQ-009 mode 00 SHALL produce lui_out = {immed[15:0], 16'h0000}.
REQ-010 mode 01 SHALL produce lui_out = {16 copies of immed[15], immed[15:0]}.
REQ-011 mode 10 SHALL produce lui_out = {16'h0000, immed[15:0]}.
REQ-012 mode 11 SHALL produce lui_out = {14 copies of immed[15], immed[15:0], 2'b00}.
REQ-013 All results SHALL be exactly 32 bits; bits shifted beyond bit 31 are discarded; no overflow flag.
REQ-014 OUT_REG=1: on each rising clk, if in_valid=1, lui_out SHALL load the result for the current immed/mode and out_valid SHALL be 1 in the following cycle.
REQ-015 OUT_REG=1: on a rising clk with in_valid=0, lui_out SHALL hold its previous value and out_valid SHALL go to 0.
REQ-016 OUT_REG=1: back-to-back valid requests SHALL be accepted every cycle (throughput 1/cycle, no stall, no backpressure).
REQ-017 OUT_REG=0: lui_out SHALL follow immed/mode combinationally; out_valid SHALL equal in_valid.
REQ-018 Changes to immed/mode while in_valid=0 SHALL NOT affect lui_out when OUT_REG=1.

Reset
REQ-019 Asserting reset SHALL immediately (without clk) force lui_out=32'h0000_0000 and out_valid=0.
REQ-020 While reset is high, in_valid SHALL be ignored; the first capture SHALL occur on the first rising clk after reset deasserts.
REQ-021 Reset asserted mid-stream SHALL discard any pending result; no result from before reset SHALL appear after it.

Structure
REQ-022 Mode encodings (LUI, SEXT, ZEXT, BRANCH) SHALL be defined as named constants in the shared MIPS package, reused by the decoder.
REQ-023 The extension logic SHALL be a purely combinational sub-module imm_ext (immed, mode -> 32-bit result); lui_unit wraps it with the optional output register.
REQ-024 No state other than the lui_out and out_valid registers SHALL exist.

Verification
REQ-025 mode 00, immed 16'h0AB5, 16'h0000, 16'h43E2, 16'h6402 in successive valid cycles -> lui_out 32'h0AB5_0000, 32'h0000_0000, 32'h43E2_0000, 32'h6402_0000 one cycle later each, out_valid=1.
REQ-026 immed 16'h8000: mode 01 -> 32'hFFFF_8000; mode 10 -> 32'h0000_8000; mode 11 -> 32'hFFFE_0000.
REQ-027 immed 16'hFFFF, mode 00 -> 32'hFFFF_0000; then in_valid=0 with immed 16'h1234 -> lui_out stays 32'hFFFF_0000, out_valid=0.
REQ-028 Assert reset between clock edges while lui_out=32'h43E2_0000 -> lui_out=0 and out_valid=0 immediately; release reset, valid immed 16'h0001 mode 00 -> 32'h0001_0000 next cycle.
REQ-029 OUT_REG=0, immed 16'h7FFF mode 11 -> lui_out 32'h0001_FFFC in the same cycle, out_valid = in_valid.
